// File: rtl/pmd901_spi_frame_rx_if.sv
// rtl/pmd901_spi_frame_rx_if.sv - record output port of the PMD901 SPI frame receiver
interface pmd901_spi_frame_rx_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 1
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic [1:0]        out_event;
    logic [1:0]        out_status;
    logic              out_len_err;

    modport master (
        output out_valid, out_data, out_ch, out_event, out_status, out_len_err,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_ch, out_event, out_status, out_len_err,
        output out_ready
    );
endinterface

// File: rtl/pmd901_spi_frame_rx.sv
// rtl/pmd901_spi_frame_rx.sv - oversampling PMD901 SPI/park/bend receiver with tagged record FIFO
module pmd901_spi_frame_rx #(
    parameter int DATA_W      = 16,
    parameter int NUM_CH      = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SPI_MODE    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sck,
    input  logic                mosi,
    input  logic [NUM_CH-1:0]   csn,
    input  logic [NUM_CH-1:0]   park,
    input  logic [NUM_CH-1:0]   bend,
    pmd901_spi_frame_rx_if.master rec,
    output logic                overflow,
    output logic [7:0]          drop_cnt
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PIN_W = 2 + 3 * NUM_CH;
    localparam int PRV_W = PIN_W - 1;
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam int REC_W = DATA_W + CH_W + 5;
    localparam logic CPOL        = 1'((SPI_MODE >> 1) & 1);
    localparam bit   SAMPLE_RISE = (SPI_MODE == 0) || (SPI_MODE == 3);
    localparam logic [PIN_W-1:0] PIN_RST = {{(2 * NUM_CH){1'b0}}, {NUM_CH{1'b1}}, 1'b0, CPOL};
    localparam logic [PRV_W-1:0] PRV_RST = {{(2 * NUM_CH){1'b0}}, {NUM_CH{1'b1}}, CPOL};
    localparam logic [CNT_W-1:0] CNT_DW  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W + 1);
    localparam logic [ARM_W-1:0] ARM_N   = ARM_W'(SYNC_STAGES + 1);
    localparam logic [1:0] EV_FRAME = 2'd0, EV_POWER = 2'd1, EV_BEND = 2'd2;

    typedef enum logic [1:0] {IDLE, SHIFT, CLOSE} state_t;

    function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] v);
        lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (v[i]) lowest = CH_W'(i);
    endfunction

    logic [PIN_W-1:0] sync_q [SYNC_STAGES];
    logic [PIN_W-1:0] cur;
    logic [PRV_W-1:0] prev_q;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;

    // mosi has no delayed copy: only its level is ever sampled
    assign cur = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_RST;
            prev_q  <= PRV_RST;
            arm_cnt <= '0;
        end else begin
            sync_q[0] <= {bend, park, csn, mosi, sck};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= {cur[PIN_W-1:2], cur[0]};
            if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

    logic              s_sck, s_mosi, p_sck;
    logic [NUM_CH-1:0] s_csn, s_park, s_bend, p_csn, p_park, p_bend;
    logic [NUM_CH-1:0] csn_fall, csn_rise, park_chg, bend_chg;
    logic              sck_edge;

    assign armed    = (arm_cnt == ARM_N);
    assign s_sck    = cur[0];
    assign s_mosi   = cur[1];
    assign s_csn    = cur[2 +: NUM_CH];
    assign s_park   = cur[2 + NUM_CH +: NUM_CH];
    assign s_bend   = cur[2 + 2 * NUM_CH +: NUM_CH];
    assign p_sck    = prev_q[0];
    assign p_csn    = prev_q[1 +: NUM_CH];
    assign p_park   = prev_q[1 + NUM_CH +: NUM_CH];
    assign p_bend   = prev_q[1 + 2 * NUM_CH +: NUM_CH];
    assign sck_edge = armed & (SAMPLE_RISE ? (s_sck & ~p_sck) : (~s_sck & p_sck));
    assign csn_fall = {NUM_CH{armed}} & p_csn & ~s_csn;
    assign csn_rise = {NUM_CH{armed}} & ~p_csn & s_csn;
    assign park_chg = {NUM_CH{armed}} & (s_park ^ p_park);
    assign bend_chg = {NUM_CH{armed}} & (s_bend ^ p_bend) & s_csn;

    state_t            state;
    logic [CH_W-1:0]   act, fall_ch;
    logic [NUM_CH-1:0] act_oh, fall_oh;
    logic [DATA_W-1:0] shreg, fr_data;
    logic [CNT_W-1:0]  bitcnt;
    logic              conflict, fr_err;

    assign fall_ch = lowest(csn_fall);
    assign fall_oh = NUM_CH'(1) << fall_ch;
    assign act_oh  = NUM_CH'(1) << act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            act      <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            conflict <= 1'b0;
            fr_data  <= '0;
            fr_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|csn_fall) begin
                    state    <= SHIFT;
                    act      <= fall_ch;
                    conflict <= |(~s_csn & ~fall_oh);
                end
                SHIFT: begin
                    if (sck_edge) begin
                        shreg <= {shreg[DATA_W-2:0], s_mosi};
                        if (bitcnt != CNT_MAX) bitcnt <= bitcnt + CNT_W'(1);
                    end
                    if (|(~s_csn & ~act_oh)) conflict <= 1'b1;
                    if (|(csn_rise & act_oh)) state <= CLOSE;
                end
                CLOSE: begin
                    fr_data  <= shreg;
                    fr_err   <= (bitcnt != CNT_DW) | conflict;
                    state    <= IDLE;
                    shreg    <= '0;
                    bitcnt   <= '0;
                    conflict <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [NUM_CH-1:0] pend_fr, pend_pw, pend_bd, gnt_fr, gnt_pw, gnt_bd;
    logic              push;
    logic [CH_W-1:0]   rec_ch;
    logic [1:0]        rec_ev, rec_st;
    logic [REC_W-1:0]  push_rec;

    // a new edge landing on a flag in its grant cycle re-arms it rather than being lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_fr <= '0;
            pend_pw <= '0;
            pend_bd <= '0;
        end else begin
            pend_fr <= (pend_fr & ~gnt_fr) | ((state == CLOSE) ? act_oh : '0);
            pend_pw <= (pend_pw & ~gnt_pw) | park_chg;
            pend_bd <= (pend_bd & ~gnt_bd) | bend_chg;
        end
    end

    always_comb begin
        gnt_fr = '0;
        gnt_pw = '0;
        gnt_bd = '0;
        push   = 1'b0;
        rec_ch = '0;
        rec_ev = EV_FRAME;
        if (|pend_fr) begin
            push   = 1'b1;
            rec_ch = lowest(pend_fr);
            gnt_fr = NUM_CH'(1) << rec_ch;
        end else if (|pend_pw) begin
            push   = 1'b1;
            rec_ch = lowest(pend_pw);
            rec_ev = EV_POWER;
            gnt_pw = NUM_CH'(1) << rec_ch;
        end else if (|pend_bd) begin
            push   = 1'b1;
            rec_ch = lowest(pend_bd);
            rec_ev = EV_BEND;
            gnt_bd = NUM_CH'(1) << rec_ch;
        end
        rec_st   = !s_park[rec_ch] ? 2'd0 : (s_bend[rec_ch] ? 2'd2 : 2'd1);
        push_rec = {(rec_ev == EV_FRAME) ? fr_data : '0, rec_ch, rec_ev, rec_st,
                    (rec_ev == EV_FRAME) & fr_err};
    end

    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop, full, wr_en, drop;

    assign pop   = (count != '0) & rec.out_ready;
    assign full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_rec;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !pop)      count <= count + (PTR_W + 1)'(1);
            else if (!wr_en && pop) count <= count - (PTR_W + 1)'(1);
            overflow <= drop;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign rec.out_valid = (count != '0);
    assign {rec.out_data, rec.out_ch, rec.out_event, rec.out_status, rec.out_len_err} = mem[rd_ptr];
endmodule
